// File: rtl/serial_packet_encoder_if.sv
// Command and UART-TX handshake bundle for serial_packet_encoder.
// The master side issues commands and plays the UART transmitter. The slave
// side is the encoder.
interface serial_packet_encoder_if #(
  parameter int DATA_BIT = 32
);
  // command side
  logic                start;
  logic [DATA_BIT-1:0] output_pattern;
  logic [DATA_BIT-1:0] freq_pattern;
  logic [3:0]          sel_out;
  logic                ch_start;
  logic                ch_stop;
  logic                ch_mode;

  // UART TX side
  logic [7:0]          tx_data;
  logic                tx_start;
  logic                tx_done_tick;

  // status
  logic                busy;
  logic                done_tick;

  modport master (
    output start, output_pattern, freq_pattern, sel_out,
    output ch_start, ch_stop, ch_mode, tx_done_tick,
    input  tx_data, tx_start, busy, done_tick
  );

  modport slave (
    input  start, output_pattern, freq_pattern, sel_out,
    input  ch_start, ch_stop, ch_mode, tx_done_tick,
    output tx_data, tx_start, busy, done_tick
  );
endinterface

// File: rtl/serial_packet_encoder.sv
// Serialises one channel command into a PACK_NUM-byte packet and hands the
// bytes one at a time to a UART transmitter.
// Byte order: output pattern MSB..LSB, freq pattern MSB..LSB, then the
// control byte {0, mode, stop, start, sel_out}.
module serial_packet_encoder #(
  parameter int DATA_BIT = 32,
  parameter int PACK_NUM = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_packet_encoder_if.slave  bus
);

  localparam int SHIFT_W = 8 * PACK_NUM;
  localparam int CNT_W   = $clog2(PACK_NUM);

  // The packet layout only works out if both patterns fill whole bytes and
  // the byte count matches them plus one control byte.
  if (DATA_BIT % 8 != 0) begin : g_bad_data_bit
    $error("serial_packet_encoder: DATA_BIT must be a multiple of 8");
  end
  if (PACK_NUM != 2 * DATA_BIT / 8 + 1) begin : g_bad_pack_num
    $error("serial_packet_encoder: PACK_NUM must equal 2*DATA_BIT/8+1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [SHIFT_W-1:0] shift_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               load;
  logic               advance;
  logic               last_byte;
  logic [7:0]         ctrl_byte;
  logic [SHIFT_W-1:0] load_word;

  assign ctrl_byte = {1'b0, bus.ch_mode, bus.ch_stop, bus.ch_start, bus.sel_out};
  assign load_word = {bus.output_pattern, bus.freq_pattern, ctrl_byte};
  assign last_byte = (cnt_q == CNT_W'(PACK_NUM - 1));

  // State register; reset aborts any packet in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic plus the load/advance strobes for the datapath.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // A done tick arriving together with start is simply not looked at.
        if (bus.start) begin
          load    = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.tx_done_tick) begin
          if (last_byte) begin
            state_d = S_DONE;
          end else begin
            advance = 1'b1;
            state_d = S_SEND;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Packet shift register and byte counter. The top byte is always the one
  // being presented to the UART, and it holds until the next accepted tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      shift_q <= load_word;
      cnt_q   <= '0;
    end else if (advance) begin
      shift_q <= {shift_q[SHIFT_W-9:0], 8'h00};
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  // Moore outputs: each decodes straight from the registered state.
  assign bus.tx_data   = shift_q[SHIFT_W-1 -: 8];
  assign bus.tx_start  = (state_q == S_SEND);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done_tick = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_packet_encoder.sv
// Self-checking bench for serial_packet_encoder: table vectors, random
// commands against a byte-level packet model, and hand-written corner cases.
module tb_serial_packet_encoder;

  localparam int DATA_BIT = 32;
  localparam int PACK_NUM = 9;
  localparam int NB       = DATA_BIT / 8;
  localparam int PW       = 8 * PACK_NUM;

  typedef struct {
    logic [DATA_BIT-1:0] out;
    logic [DATA_BIT-1:0] freq;
    logic [3:0]          sel;
    logic                cs;
    logic                cp;
    logic                cm;
  } cmd_t;

  typedef struct {
    cmd_t          cmd;
    logic [PW-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_packet_encoder_if #(.DATA_BIT(DATA_BIT)) bus ();

  serial_packet_encoder #(
    .DATA_BIT(DATA_BIT),
    .PACK_NUM(PACK_NUM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  got_q[$];

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: byte i of the packet, straight from the field layout.
  function automatic logic [7:0] model_byte(input cmd_t c, input int i);
    int v;
    if (i < NB)          return 8'((c.out  >> (8 * (NB - 1 - i))) & 'hFF);
    else if (i < 2 * NB) return 8'((c.freq >> (8 * (2 * NB - 1 - i))) & 'hFF);
    v = 64 * int'(c.cm) + 32 * int'(c.cp) + 16 * int'(c.cs) + int'(c.sel);
    return 8'(v);
  endfunction

  function automatic logic [PW-1:0] model_pkt(input cmd_t c);
    logic [PW-1:0] p = '0;
    for (int i = 0; i < PACK_NUM; i++) p = (p << 8) | PW'(model_byte(c, i));
    return p;
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.out  = $urandom;
    c.freq = $urandom;
    c.sel  = 4'($urandom);
    c.cs   = 1'($urandom);
    c.cp   = 1'($urandom);
    c.cm   = 1'($urandom);
    return c;
  endfunction

  task automatic drive_cmd(input cmd_t c);
    bus.output_pattern = c.out;
    bus.freq_pattern   = c.freq;
    bus.sel_out        = c.sel;
    bus.ch_start       = c.cs;
    bus.ch_stop        = c.cp;
    bus.ch_mode        = c.cm;
  endtask

  // Sends one packet while acting as the UART (done tick `delay` cycles
  // after each byte is loaded). gmask bit b pulses start while waiting on
  // byte b; spur raises a done tick during each tx_start cycle; done_start
  // pulses start in the done cycle; tick_start raises a done tick together
  // with the accepted start.
  task automatic send_pkt(input cmd_t c, input logic [PW-1:0] exp, input int delay,
                          input int gmask, input bit spur, input bit done_start,
                          input bit tick_start, input string tag);
    int w;
    int pulses = 0;
    drive_cmd(c);
    bus.start = 1'b1;
    if (tick_start) bus.tx_done_tick = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.tx_done_tick = 1'b0;
    chk({tag, " start_lat"}, PW'(bus.tx_start), PW'(1));
    chk({tag, " busy"}, PW'(bus.busy), PW'(1));
    // Inputs wander after accept; they must not reach the packet.
    drive_cmd(rand_cmd());
    got_q.delete();
    for (int b = 0; b < PACK_NUM; b++) begin
      w = 0;
      while (!bus.tx_start && w < 100) begin
        tick();
        w++;
      end
      if (!bus.tx_start) begin
        chk({tag, " tx_start_timeout"}, PW'(0), PW'(1));
        break;
      end
      got_q.push_back(bus.tx_data);
      pulses++;
      if (spur) bus.tx_done_tick = 1'b1;
      tick();
      bus.tx_done_tick = 1'b0;
      chk({tag, " no_back2back"}, PW'(bus.tx_start), PW'(0));
      for (int d = 0; d < delay; d++) begin
        if (gmask[b] && d == 0) bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
      end
      bus.tx_done_tick = 1'b1;
      tick();
      bus.tx_done_tick = 1'b0;
      if (b < PACK_NUM - 1) chk({tag, " tick_lat"}, PW'(bus.tx_start), PW'(1));
      else                  chk({tag, " done_lat"}, PW'(bus.done_tick), PW'(1));
    end
    if (done_start) bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({tag, " done_once"}, PW'(bus.done_tick), PW'(0));
    chk({tag, " idle"}, PW'(bus.busy), PW'(0));
    tick();
    chk({tag, " not_queued"}, PW'(bus.busy), PW'(0));
    chk({tag, " pulses"}, PW'(pulses), PW'(PACK_NUM));
    for (int i = 0; i < PACK_NUM; i++)
      if (i < got_q.size())
        chk({tag, $sformatf(" byte%0d", i)}, PW'(got_q[i]), PW'(exp[8 * (PACK_NUM - 1 - i) +: 8]));
  endtask

  vec_t vecs[5];

  initial begin
    cmd_t c;
    int   w;

    vecs[0] = '{'{32'h1234_5678, 32'h0000_FFFF, 4'd3, 1'b1, 1'b0, 1'b1}, 72'h12345678_0000FFFF_53};
    vecs[1] = '{'{32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, 1'b1}, 72'hFFFFFFFF_FFFFFFFF_7F};
    vecs[2] = '{'{32'h0000_0000, 32'h0000_0000, 4'h0, 1'b0, 1'b0, 1'b0}, 72'h00000000_00000000_00};
    vecs[3] = '{'{32'hA5A5_0F0F, 32'h8000_0001, 4'hA, 1'b0, 1'b1, 1'b0}, 72'hA5A50F0F_80000001_2A};
    vecs[4] = '{'{32'hDEAD_BEEF, 32'h0123_4567, 4'h5, 1'b1, 1'b1, 1'b0}, 72'hDEADBEEF_01234567_35};

    bus.start = 1'b0;
    bus.tx_done_tick = 1'b0;
    drive_cmd(vecs[2].cmd);

    // reset state
    tick();
    chk("rst tx_data", PW'(bus.tx_data), PW'(0));
    chk("rst tx_start", PW'(bus.tx_start), PW'(0));
    chk("rst busy", PW'(bus.busy), PW'(0));
    chk("rst done", PW'(bus.done_tick), PW'(0));
    rst = 1'b0;
    tick();

    // table vectors
    foreach (vecs[k]) send_pkt(vecs[k].cmd, vecs[k].exp, 1 + k, 0, 1'b0, 1'b0, 1'b0, $sformatf("vec%0d", k));

    // long UART delay, start pulses during bytes 0 and 4 and during done
    send_pkt(vecs[0].cmd, vecs[0].exp, 10, 'b1_0001, 1'b0, 1'b1, 1'b0, "ignore_start");

    // spurious done ticks: alone in idle, with start, and in every send cycle
    bus.tx_done_tick = 1'b1;
    tick();
    bus.tx_done_tick = 1'b0;
    chk("idle_tick busy", PW'(bus.busy), PW'(0));
    chk("idle_tick tx_start", PW'(bus.tx_start), PW'(0));
    send_pkt(vecs[3].cmd, vecs[3].exp, 2, 0, 1'b1, 1'b0, 1'b1, "spurious");

    // random commands against the model
    for (int r = 0; r < 20; r++) begin
      c = rand_cmd();
      send_pkt(c, model_pkt(c), int'($urandom_range(1, 4)), int'($urandom_range(0, 511)),
               1'($urandom), 1'($urandom), 1'($urandom), $sformatf("rand%0d", r));
    end

    // reset after byte 5 aborts the packet
    drive_cmd(vecs[4].cmd);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int b = 0; b < 5; b++) begin
      w = 0;
      while (!bus.tx_start && w < 100) begin
        tick();
        w++;
      end
      tick();
      tick();
      bus.tx_done_tick = 1'b1;
      tick();
      bus.tx_done_tick = 1'b0;
    end
    chk("pre_rst tx_start", PW'(bus.tx_start), PW'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst tx_data", PW'(bus.tx_data), PW'(0));
    chk("mid_rst tx_start", PW'(bus.tx_start), PW'(0));
    chk("mid_rst busy", PW'(bus.busy), PW'(0));
    chk("mid_rst done", PW'(bus.done_tick), PW'(0));
    bus.tx_done_tick = 1'b1;
    tick();
    bus.tx_done_tick = 1'b0;
    chk("in_rst tx_start", PW'(bus.tx_start), PW'(0));
    rst = 1'b0;
    tick();
    tick();
    chk("post_rst busy", PW'(bus.busy), PW'(0));
    chk("post_rst tx_start", PW'(bus.tx_start), PW'(0));
    c = rand_cmd();
    c.sel = 4'hF;
    c.cs  = 1'b0;
    c.cp  = 1'b0;
    c.cm  = 1'b0;
    chk("ctrl_0F model", PW'(model_byte(c, PACK_NUM - 1)), PW'(8'h0F));
    send_pkt(c, model_pkt(c), 3, 0, 1'b0, 1'b0, 1'b0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
